// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and datapath.
// Holds ALU operation codes (also consumed by the ALU), opcode/funct
// constants, the 4-bit FSM state encoding and the ALU-op class used by the decoder.
package multicycle_ctrl_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_NOT = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_NOT = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC_R = 4'd7,
    ST_RWB    = 4'd8,
    ST_EXEC_I = 4'd9,
    ST_IWB    = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12
  } state_t;

  // How the current state wants the ALU code chosen
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_ITYPE = 2'd3
  } alu_class_t;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational ALU-op decoder: maps (state class, opcode, funct) to alu_cnt.
// Ports: cls_i (state class), opcode_i, funct_i -> alu_cnt_o, funct_vld_o
// (funct_vld_o is high for any supported R-type funct, independent of class).
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  alu_class_t  cls_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  alu_cnt_o,
  output logic        funct_vld_o
);

  logic [3:0] r_cnt;

  always_comb begin
    r_cnt       = ALU_ADD;
    funct_vld_o = 1'b1;
    case (funct_i)
      FN_ADD:  r_cnt = ALU_ADD;
      FN_SUB:  r_cnt = ALU_SUB;
      FN_NOT:  r_cnt = ALU_NOT;
      FN_SLL:  r_cnt = ALU_SLL;
      FN_SRL:  r_cnt = ALU_SRL;
      FN_AND:  r_cnt = ALU_AND;
      FN_OR:   r_cnt = ALU_OR;
      FN_SLT:  r_cnt = ALU_SLT;
      default: funct_vld_o = 1'b0;  // unknown funct falls back to add
    endcase
  end

  always_comb begin
    alu_cnt_o = ALU_ADD;
    case (cls_i)
      CLS_SUB:   alu_cnt_o = ALU_SUB;
      CLS_RTYPE: alu_cnt_o = r_cnt;
      CLS_ITYPE: begin
        case (opcode_i)
          OP_ANDI: alu_cnt_o = ALU_AND;
          OP_ORI:  alu_cnt_o = ALU_OR;
          OP_SLTI: alu_cnt_o = ALU_SLT;
          default: alu_cnt_o = ALU_ADD;
        endcase
      end
      default:   alu_cnt_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath (Moore outputs, plus pc_en/ir_write
// which follow zero/mem_ready combinationally). Inputs: clk, rst_n, opcode, funct,
// zero, mem_ready. Outputs: ALU code/selects, PC/memory/register-file controls, illegal_op.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_cnt,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op
);

  state_t     state_q, state_d;
  logic [5:0] op_q;  // opcode captured in DECODE; later states use this copy
  alu_class_t cls;
  logic       funct_vld;
  logic       pc_write, pc_write_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= opcode;
    end
  end

  alu_op_decode u_alu_op_decode (
    .cls_i       (cls),
    .opcode_i    (op_q),
    .funct_i     (funct),
    .alu_cnt_o   (alu_cnt),
    .funct_vld_o (funct_vld)
  );

  assign pc_en = pc_write | (pc_write_cond & zero);

  always_comb begin
    state_d       = state_q;
    cls           = CLS_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 commit only in the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_RTYPE)                   state_d = ST_EXEC_R;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = ST_MEMADR;
        else if (opcode == OP_BEQ)                state_d = ST_BRANCH;
        else if (opcode == OP_J)                  state_d = ST_JUMP;
        else if (is_itype(opcode))                state_d = ST_EXEC_I;
        else begin
          illegal_op = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        cls       = CLS_RTYPE;
        state_d   = ST_RWB;
      end
      ST_RWB: begin
        reg_dst   = 1'b1;
        reg_write = funct_vld;
        state_d   = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        cls       = CLS_ITYPE;
        ext_zero  = (op_q == OP_ANDI) || (op_q == OP_ORI);
        state_d   = ST_IWB;
      end
      ST_IWB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        cls           = CLS_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: builds the expected per-cycle control trace
// of each instruction from the ISA rules, then drives the DUT one cycle per step.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [3:0] alu_cnt;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_src;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_cnt(alu_cnt), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_src(pc_src), .pc_en(pc_en),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic [3:0] alu_cnt;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } out_t;

  typedef struct {
    string      tag;
    logic       rdy;
    logic       z;
    logic [5:0] opc;
    out_t       o;
  } step_t;

  out_t dut_o;
  assign dut_o = {alu_cnt, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, iord, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op};

  step_t q[$];
  int checks = 0;
  int errors = 0;

  logic [5:0] legal_ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                6'b001000, 6'b001100, 6'b001101, 6'b001010};
  logic [5:0] r_functs [8] = '{6'b100000, 6'b100010, 6'b100111, 6'b000000,
                               6'b000010, 6'b100100, 6'b100101, 6'b101010};

  function automatic logic [5:0] rj();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // R-type ALU code table: position in r_functs equals the ALU code
  function automatic logic [3:0] rcode(input logic [5:0] fn, output bit known);
    known = 1'b0;
    foreach (r_functs[i]) if (r_functs[i] == fn) begin
      known = 1'b1;
      return 4'(i);
    end
    return 4'b0000;
  endfunction

  task automatic check(input string tag, input out_t obs, input out_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic rdy, input logic z,
                      input logic [5:0] opc, input out_t o);
    step_t s;
    s.tag = tag; s.rdy = rdy; s.z = z; s.opc = opc; s.o = o;
    q.push_back(s);
  endtask

  // Expected cycle trace for one instruction starting at FETCH entry.
  // The opcode is only valid in DECODE; every other cycle shows junk on it.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    out_t o;
    bit   known;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_read = 1; o.alu_src_b = 2'b01;
      push("fetch_wait", 1'b0, rb(), rj(), o);
    end
    o = '0; o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = 1; o.pc_en = 1;
    push("fetch", 1'b1, rb(), rj(), o);
    o = '0; o.alu_src_b = 2'b11; o.illegal_op = !is_legal(op);
    push("decode", rb(), rb(), op, o);
    if (!is_legal(op)) return;
    if (op == 6'b000000) begin
      o = '0; o.alu_src_a = 1; o.alu_cnt = rcode(fn, known);
      push("exec_r", rb(), rb(), rj(), o);
      o = '0; o.reg_dst = 1; o.reg_write = known;
      push("rwb", rb(), rb(), rj(), o);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
      push("memadr", rb(), rb(), rj(), o);
      o = '0; o.iord = 1;
      if (op == 6'b100011) o.mem_read = 1; else o.mem_write = 1;
      for (int i = 0; i < mw; i++) push("mem_wait", 1'b0, rb(), rj(), o);
      push("mem_done", 1'b1, rb(), rj(), o);
      if (op == 6'b100011) begin
        o = '0; o.reg_write = 1; o.mem_to_reg = 1;
        push("memwb", rb(), rb(), rj(), o);
      end
    end else if (op == 6'b000100) begin
      o = '0; o.alu_src_a = 1; o.alu_cnt = 4'b0001; o.pc_src = 2'b01; o.pc_en = z;
      push("branch", rb(), z, rj(), o);
    end else if (op == 6'b000010) begin
      o = '0; o.pc_en = 1; o.pc_src = 2'b10;
      push("jump", rb(), rb(), rj(), o);
    end else begin
      o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
      case (op)
        6'b001100: begin o.alu_cnt = 4'b0101; o.ext_zero = 1; end
        6'b001101: begin o.alu_cnt = 4'b0110; o.ext_zero = 1; end
        6'b001010: o.alu_cnt = 4'b0111;
        default:   o.alu_cnt = 4'b0000;
      endcase
      push("exec_i", rb(), rb(), rj(), o);
      o = '0; o.reg_write = 1;
      push("iwb", rb(), rb(), rj(), o);
    end
  endtask

  // Execute up to n queued steps: drive at posedge+1, check at posedge+2
  task automatic run(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      opcode = s.opc; mem_ready = s.rdy; zero = s.z;
      #1;
      check(s.tag, dut_o, s.o);
      @(posedge clk); #1;
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    funct = fn;
    build(op, fn, z, fw, mw);
    run(1000);
  endtask

  initial begin
    logic [5:0] op, fn;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_async", dut_o, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", dut_o, '0);
    rst_n = 1'b1;
    push("idle", rb(), rb(), rj(), '0);
    run(1);

    // Directed instructions
    instr(6'b000000, 6'b100000, 1'b0, 0, 0);   // R-type add
    instr(6'b100011, 6'b000000, 1'b0, 0, 2);   // lw, 2 wait cycles in MEMRD
    instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
    instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
    instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // illegal opcode
    instr(6'b000000, 6'b111111, 1'b0, 0, 0);   // unknown funct
    instr(6'b000010, 6'b000000, 1'b0, 1, 0);   // j with fetch stall
    instr(6'b101011, 6'b000000, 1'b0, 0, 1);   // sw with a write stall
    for (int i = 5; i < 9; i++) instr(legal_ops[i], 6'b000000, 1'b0, 0, 0);
    foreach (r_functs[i]) instr(6'b000000, r_functs[i], 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rj(); while (is_legal(op));
      end else op = legal_ops[$urandom_range(0, 8)];
      fn = ($urandom_range(0, 3) == 0) ? rj() : r_functs[$urandom_range(0, 7)];
      instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset arriving while a store waits on memory
    funct = 6'b000000;
    build(6'b101011, 6'b000000, 1'b0, 0, 6);
    run(5);
    mem_ready = 1'b0;
    #1;
    checks++;
    assert (mem_write === 1'b1) else begin
      errors++;
      $error("FAIL memwr_before_reset observed=%b expected=1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    check("reset_mid_memwr", dut_o, '0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_mid_held", dut_o, '0);
    rst_n = 1'b1;
    push("idle_after", rb(), rb(), rj(), '0);
    run(1);
    instr(6'b001101, 6'b000000, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
